// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared encodings for the traffic signal monitor
package traffic_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [2:0] {
    PH_UNKNOWN = 3'd0,
    PH_NS_GO   = 3'd1,
    PH_WE_GO   = 3'd2,
    PH_ALL_RED = 3'd3,
    PH_FAULT   = 3'd4
  } phase_e;

  typedef enum logic [1:0] {GO_NONE, GO_NS, GO_WE} last_go_e;

  typedef enum logic [1:0] {CLS_NSGO, CLS_WEGO, CLS_ALLRED, CLS_BAD} lamp_cls_e;

  localparam logic [2:0] FE_NONE     = 3'd0;
  localparam logic [2:0] FE_CONFLICT = 3'd1;
  localparam logic [2:0] FE_SEG      = 3'd2;
  localparam logic [2:0] FE_STEP     = 3'd3;
  localparam logic [2:0] FE_MISMATCH = 3'd4;
  localparam logic [2:0] FE_STALL    = 3'd5;

  function automatic logic [6:0] bcd2bin(input logic [3:0] tens, input logic [3:0] units);
    return ({3'b000, tens} * 7'd10) + {3'b000, units};
  endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// rtl/seg7_to_bcd.sv - combinational seven-segment to decimal digit decoder
module seg7_to_bcd
  import traffic_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] digit_o,
  output logic       valid_o
);

  always_comb begin
    digit_o = 4'd0;
    valid_o = 1'b1;
    case (seg_i)
      SEG_0:   digit_o = 4'd0;
      SEG_1:   digit_o = 4'd1;
      SEG_2:   digit_o = 4'd2;
      SEG_3:   digit_o = 4'd3;
      SEG_4:   digit_o = 4'd4;
      SEG_5:   digit_o = 4'd5;
      SEG_6:   digit_o = 4'd6;
      SEG_7:   digit_o = 4'd7;
      SEG_8:   digit_o = 4'd8;
      SEG_9:   digit_o = 4'd9;
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/traffic_signal_monitor.sv
// rtl/traffic_signal_monitor.sv - checks lamp and countdown outputs of a traffic controller
module traffic_signal_monitor
  import traffic_pkg::*;
#(
  parameter int HOLD_MAX = 1000,
  parameter int HOLD_W   = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       clr,
  input  logic       GSN1,
  input  logic       GSN2,
  input  logic       GWE1,
  input  logic       GWE2,
  input  logic       RNS,
  input  logic       RWE,
  input  logic [6:0] SN1D1,
  input  logic [6:0] SN1D2,
  input  logic [6:0] SN2D1,
  input  logic [6:0] SN2D2,
  input  logic [6:0] WE1D1,
  input  logic [6:0] WE1D2,
  input  logic [6:0] WE2D1,
  input  logic [6:0] WE2D2,
  output logic [2:0] phase,
  output logic [6:0] ns_count,
  output logic [6:0] we_count,
  output logic       err_conflict,
  output logic       err_seg,
  output logic       err_step,
  output logic       err_mismatch,
  output logic       err_stall,
  output logic       fault,
  output logic [2:0] first_err
);

  localparam logic [HOLD_W-1:0] HMAX = HOLD_W'(HOLD_MAX);

  logic [5:0]      lamp_q;
  logic [7:0][6:0] seg_q;
  logic            clr_q, s1_vld_q;

  phase_e          phase_q, phase_d;
  last_go_e        last_go_q, last_go_d;
  logic            phase_chg_q, prev_valid_q, fault_q, fault_d;
  logic [6:0]      ns_q, we_q;
  logic [HOLD_W-1:0] hold_ns_q, hold_ns_d, hold_we_q, hold_we_d;
  logic [2:0]      first_q, first_d, err_code;
  logic            conf_q, seg_err_q, step_q, mism_q, stall_q;

  logic [7:0][3:0] dig;
  logic [7:0]      dv;

  for (genvar g = 0; g < 8; g++) begin : g_dec
    seg7_to_bcd u_dec (.seg_i(seg_q[g]), .digit_o(dig[g]), .valid_o(dv[g]));
  end

  logic       gn, gw, rns, rwe, seg_ok, chk, conflict, blocked, phase_chg, reload;
  logic       ns_chg, we_chg, stall_ns, stall_we;
  logic       conf_d, seg_err_d, step_d, mism_d, stall_d, any_err;
  logic [6:0] sn1_v, sn2_v, we1_v, we2_v, ns_dec, we_dec;
  lamp_cls_e  cls;

  always_comb begin
    gn     = lamp_q[5] | lamp_q[4];
    gw     = lamp_q[3] | lamp_q[2];
    rns    = lamp_q[1];
    rwe    = lamp_q[0];
    if (gn && !gw && rwe && !rns)      cls = CLS_NSGO;
    else if (gw && !gn && rns && !rwe) cls = CLS_WEGO;
    else if (!gn && !gw && rns && rwe) cls = CLS_ALLRED;
    else                               cls = CLS_BAD;
    seg_ok = &dv;
    chk    = s1_vld_q && seg_ok;
    sn1_v  = bcd2bin(dig[0], dig[1]);
    sn2_v  = bcd2bin(dig[2], dig[3]);
    we1_v  = bcd2bin(dig[4], dig[5]);
    we2_v  = bcd2bin(dig[6], dig[7]);
  end

  // A GO may not follow ALL_RED when it was also the GO before ALL_RED.
  always_comb begin
    phase_d   = phase_q;
    last_go_d = last_go_q;
    conflict  = 1'b0;
    blocked   = (phase_q == PH_FAULT) && !clr_q;
    if (!s1_vld_q) begin
      phase_d = phase_q;
    end else if (cls == CLS_BAD) begin
      phase_d  = PH_FAULT;
      conflict = 1'b1;
    end else if (!blocked) begin
      case (cls)
        CLS_NSGO: begin
          if (phase_q == PH_ALL_RED && last_go_q == GO_NS) begin
            phase_d  = PH_FAULT;
            conflict = 1'b1;
          end else begin
            phase_d   = PH_NS_GO;
            last_go_d = GO_NS;
          end
        end
        CLS_WEGO: begin
          if (phase_q == PH_ALL_RED && last_go_q == GO_WE) begin
            phase_d  = PH_FAULT;
            conflict = 1'b1;
          end else begin
            phase_d   = PH_WE_GO;
            last_go_d = GO_WE;
          end
        end
        default: begin
          phase_d = PH_ALL_RED;
          if (phase_q == PH_UNKNOWN || phase_q == PH_FAULT) last_go_d = GO_NONE;
        end
      endcase
    end
  end

  always_comb begin
    phase_chg = (phase_d != phase_q);
    reload    = phase_chg || phase_chg_q;
    ns_dec    = ns_q - 7'd1;
    we_dec    = we_q - 7'd1;
    ns_chg    = chk && (sn1_v != ns_q);
    we_chg    = chk && (we1_v != we_q);
    conf_d    = conflict;
    seg_err_d = s1_vld_q && !seg_ok;
    step_d    = chk && prev_valid_q && !reload &&
                ((ns_chg && sn1_v != ns_dec) || (we_chg && we1_v != we_dec));
    mism_d    = chk && ((sn1_v != sn2_v) || (we1_v != we2_v));

    hold_ns_d = hold_ns_q;
    stall_ns  = 1'b0;
    if (ns_chg || phase_chg) hold_ns_d = '0;
    else if (chk && hold_ns_q != HMAX) begin
      hold_ns_d = hold_ns_q + 1'b1;
      stall_ns  = (hold_ns_d == HMAX);
    end
    hold_we_d = hold_we_q;
    stall_we  = 1'b0;
    if (we_chg || phase_chg) hold_we_d = '0;
    else if (chk && hold_we_q != HMAX) begin
      hold_we_d = hold_we_q + 1'b1;
      stall_we  = (hold_we_d == HMAX);
    end
    stall_d = stall_ns || stall_we;

    if (conf_d)         err_code = FE_CONFLICT;
    else if (seg_err_d) err_code = FE_SEG;
    else if (step_d)    err_code = FE_STEP;
    else if (mism_d)    err_code = FE_MISMATCH;
    else if (stall_d)   err_code = FE_STALL;
    else                err_code = FE_NONE;
    any_err = (err_code != FE_NONE);
    // clr wipes the old sticky state, but an error in the same cycle still lands.
    fault_d = clr_q ? any_err : (fault_q || any_err);
    first_d = (clr_q || first_q == FE_NONE) ? err_code : first_q;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      lamp_q       <= '0;
      seg_q        <= '0;
      clr_q        <= 1'b0;
      s1_vld_q     <= 1'b0;
      phase_q      <= PH_UNKNOWN;
      last_go_q    <= GO_NONE;
      phase_chg_q  <= 1'b0;
      prev_valid_q <= 1'b0;
      ns_q         <= '0;
      we_q         <= '0;
      hold_ns_q    <= '0;
      hold_we_q    <= '0;
      fault_q      <= 1'b0;
      first_q      <= FE_NONE;
      conf_q       <= 1'b0;
      seg_err_q    <= 1'b0;
      step_q       <= 1'b0;
      mism_q       <= 1'b0;
      stall_q      <= 1'b0;
    end else begin
      lamp_q       <= {GSN1, GSN2, GWE1, GWE2, RNS, RWE};
      seg_q        <= {WE2D2, WE2D1, WE1D2, WE1D1, SN2D2, SN2D1, SN1D2, SN1D1};
      clr_q        <= clr;
      s1_vld_q     <= 1'b1;
      phase_q      <= phase_d;
      last_go_q    <= last_go_d;
      phase_chg_q  <= phase_chg;
      if (chk) begin
        prev_valid_q <= 1'b1;
        ns_q         <= sn1_v;
        we_q         <= we1_v;
      end
      hold_ns_q    <= hold_ns_d;
      hold_we_q    <= hold_we_d;
      fault_q      <= fault_d;
      first_q      <= first_d;
      conf_q       <= conf_d;
      seg_err_q    <= seg_err_d;
      step_q       <= step_d;
      mism_q       <= mism_d;
      stall_q      <= stall_d;
    end
  end

  assign phase        = phase_q;
  assign ns_count     = ns_q;
  assign we_count     = we_q;
  assign err_conflict = conf_q;
  assign err_seg      = seg_err_q;
  assign err_step     = step_q;
  assign err_mismatch = mism_q;
  assign err_stall    = stall_q;
  assign fault        = fault_q;
  assign first_err    = first_q;

endmodule

// File: tb/tb_traffic_signal_monitor.sv
// tb/tb_traffic_signal_monitor.sv - directed self-checking bench for traffic_signal_monitor
module tb_traffic_signal_monitor;

  logic       CLK, RESET, clr;
  logic       GSN1, GSN2, GWE1, GWE2, RNS, RWE;
  logic [6:0] SN1D1, SN1D2, SN2D1, SN2D2, WE1D1, WE1D2, WE2D1, WE2D2;
  logic [2:0] phase, first_err;
  logic [6:0] ns_count, we_count;
  logic       err_conflict, err_seg, err_step, err_mismatch, err_stall, fault;

  int n_tests = 0;
  int n_fail  = 0;
  int n_conf = 0, n_seg = 0, n_step = 0, n_mism = 0, n_stall = 0;
  int base_conf, base_step, base_seg, base_mism, base_stall;

  traffic_signal_monitor #(.HOLD_MAX(20), .HOLD_W(16)) dut (
    .CLK(CLK), .RESET(RESET), .clr(clr),
    .GSN1(GSN1), .GSN2(GSN2), .GWE1(GWE1), .GWE2(GWE2), .RNS(RNS), .RWE(RWE),
    .SN1D1(SN1D1), .SN1D2(SN1D2), .SN2D1(SN2D1), .SN2D2(SN2D2),
    .WE1D1(WE1D1), .WE1D2(WE1D2), .WE2D1(WE2D1), .WE2D2(WE2D2),
    .phase(phase), .ns_count(ns_count), .we_count(we_count),
    .err_conflict(err_conflict), .err_seg(err_seg), .err_step(err_step),
    .err_mismatch(err_mismatch), .err_stall(err_stall),
    .fault(fault), .first_err(first_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    n_conf  += int'(err_conflict);
    n_seg   += int'(err_seg);
    n_step  += int'(err_step);
    n_mism  += int'(err_mismatch);
    n_stall += int'(err_stall);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic snap();
    base_conf = n_conf; base_seg = n_seg; base_step = n_step;
    base_mism = n_mism; base_stall = n_stall;
  endtask

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic set_vals(input int sn1, input int sn2, input int we1, input int we2);
    SN1D1 = seg(sn1 / 10); SN1D2 = seg(sn1 % 10);
    SN2D1 = seg(sn2 / 10); SN2D2 = seg(sn2 % 10);
    WE1D1 = seg(we1 / 10); WE1D2 = seg(we1 % 10);
    WE2D1 = seg(we2 / 10); WE2D2 = seg(we2 % 10);
  endtask

  task automatic lamps_ns();  {GSN1, GSN2, GWE1, GWE2, RNS, RWE} = 6'b110001; endtask
  task automatic lamps_we();  {GSN1, GSN2, GWE1, GWE2, RNS, RWE} = 6'b001110; endtask
  task automatic lamps_ar();  {GSN1, GSN2, GWE1, GWE2, RNS, RWE} = 6'b000011; endtask

  initial begin
    RESET = 1'b0;
    clr   = 1'b0;
    lamps_ns();
    set_vals(25, 25, 25, 25);
    ticks(2);
    check("rst_phase", phase, 0);
    check("rst_ns", ns_count, 0);
    check("rst_fault", fault, 0);
    check("rst_first", first_err, 0);

    RESET = 1'b1;
    ticks(2);
    check("start_phase", phase, 1);
    check("start_ns", ns_count, 25);
    snap();
    for (int i = 1; i <= 5; i++) begin
      ticks(10);
      set_vals(25 - i, 25 - i, 25 - i, 25 - i);
    end
    ticks(2);
    check("count_ns", ns_count, 20);
    check("count_we", we_count, 20);
    check("count_phase", phase, 1);
    check("count_errs", (n_conf - base_conf) + (n_seg - base_seg) + (n_step - base_step)
                        + (n_mism - base_mism) + (n_stall - base_stall), 0);
    check("count_first", first_err, 0);

    GWE1 = 1'b1;
    tick();
    GWE1 = 1'b0;
    tick();
    check("conf_pulse", err_conflict, 1);
    check("conf_phase", phase, 4);
    check("conf_fault", fault, 1);
    check("conf_first", first_err, 1);
    tick();
    check("conf_once", err_conflict, 0);
    check("fault_hold", phase, 4);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    check("clr_phase", phase, 1);
    check("clr_fault", fault, 0);
    check("clr_first", first_err, 0);

    SN1D2 = 7'b1010101;
    tick();
    set_vals(20, 20, 20, 20);
    tick();
    check("seg_pulse", err_seg, 1);
    check("seg_first", first_err, 2);
    check("seg_hold_ns", ns_count, 20);
    check("seg_no_step", err_step, 0);
    ticks(2);
    check("seg_once", err_seg, 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    check("clr2_first", first_err, 0);

    set_vals(18, 18, 18, 18);
    ticks(2);
    check("step_pulse", err_step, 1);
    check("step_first", first_err, 3);
    set_vals(1, 1, 1, 1);
    ticks(3);
    snap();
    lamps_ar();
    set_vals(30, 30, 30, 30);
    ticks(4);
    check("reload_step", n_step - base_step, 0);
    check("reload_conf", n_conf - base_conf, 0);
    check("reload_phase", phase, 3);
    check("reload_ns", ns_count, 30);
    set_vals(0, 0, 0, 0);
    ticks(3);
    set_vals(99, 99, 99, 99);
    ticks(2);
    check("wrap_step", err_step, 1);
    check("wrap_ns", ns_count, 99);
    lamps_ns();
    ticks(2);
    check("same_go_conf", err_conflict, 1);
    check("same_go_phase", phase, 4);
    lamps_we();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    check("reenter_phase", phase, 2);
    check("reenter_fault", fault, 0);

    set_vals(15, 16, 15, 15);
    ticks(2);
    check("mism_pulse", err_mismatch, 1);
    check("mism_step", err_step, 1);
    check("prio_first", first_err, 3);
    set_vals(15, 15, 15, 15);
    ticks(3);
    snap();
    ticks(30);
    check("stall_once", n_stall - base_stall, 1);
    check("stall_no_mism", n_mism - base_mism, 0);

    check("pre_rst_fault", fault, 1);
    RESET = 1'b0;
    #1;
    check("arst_phase", phase, 0);
    check("arst_fault", fault, 0);
    check("arst_first", first_err, 0);
    check("arst_ns", ns_count, 0);
    set_vals(50, 50, 50, 50);
    tick();
    RESET = 1'b1;
    snap();
    ticks(5);
    check("post_rst_step", n_step - base_step, 0);
    check("post_rst_seg", n_seg - base_seg, 0);
    check("post_rst_ns", ns_count, 50);
    check("post_rst_phase", phase, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_signal_monitor.md
Name: traffic_signal_monitor

Overview:
- Receiving-end checker for the traffic_control outputs: the six lamp lines and the eight seven-segment digit buses.
- Decodes the segment codes back to binary countdown values and tracks the signal phase with an FSM.
- Flags lamp conflicts, illegal segment codes, bad countdown steps, display mismatches and stalled counters.
- Sits beside traffic_control in the top level and in the bench, with its error outputs brought out to LEDs or a scoreboard.

Parameters:
- HOLD_MAX, 1000: max cycles a displayed countdown may stay unchanged before err_stall.
- HOLD_W, 16: width of the hold counters; HOLD_MAX < 2**HOLD_W.

Ports:
- CLK  in  1  system clock; all logic is rising-edge.
- RESET  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear of sticky fault and first_err.
- GSN1, GSN2, GWE1, GWE2  in  1 each  green lamps, N-S and W-E.
- RNS, RWE  in  1 each  red lamps, N-S and W-E.
- SN1D1, SN1D2, SN2D1, SN2D2, WE1D1, WE1D2, WE2D1, WE2D2  in  7 each  segment codes; D1 is tens, D2 is units.
- phase  out  3  current phase encoding (package).
- ns_count, we_count  out  7 each  decoded SN1 and WE1 values, 0..99.
- err_conflict, err_seg, err_step, err_mismatch, err_stall  out  1 each  single-cycle error pulses.
- fault  out  1  sticky OR of all errors.
- first_err  out  3  code of the first error since reset or clr; 0 means none.

Behaviour:
- Reset (RESET=0, asynchronous): all outputs 0. phase=UNKNOWN, input registers 0, prev_valid=0, hold counters 0.
- Latency:
  - All inputs are registered once (stage S1).
  - Decode, checks and FSM results are registered (stage S2).
  - An input change is visible on the outputs 2 cycles later.
- Segment code, active-high, bit6..0 = g f e d c b a:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - Any other code, including blank, is invalid.
  - Value = 10*tens + units, 7-bit unsigned.
- err_seg: any of the 8 digits invalid in S1. On that cycle the step, mismatch and stall checks are skipped and the previous values are retained.
- err_mismatch: SN1 value != SN2 value, or WE1 value != WE2 value.
- Lamp classes, where GN=GSN1|GSN2 and GW=GWE1|GWE2:
  - NSGO: GN & !GW & RWE & !RNS.
  - WEGO: GW & !GN & RNS & !RWE.
  - ALLRED: !GN & !GW & RNS & RWE.
  - Anything else is a conflict: err_conflict fires and phase goes to FAULT.
- FSM states: UNKNOWN, NS_GO, WE_GO, ALL_RED, FAULT. A last_go register remembers the last GO state.
  - UNKNOWN goes to whichever class is seen; ALLRED from UNKNOWN leaves last_go unset.
  - NS_GO may go to ALL_RED or WE_GO. WE_GO may go to ALL_RED or NS_GO.
  - ALL_RED may only go to the opposite of last_go. Returning to the same GO is err_conflict, then FAULT.
  - FAULT is left only by reset, or by clr with a legal class present; it then re-enters as if from UNKNOWN.
- Step check, per direction using the SN1 and WE1 values:
  - Applies when prev_valid=1 and the value differs from the previous sample.
  - Legal if new = old-1.
  - Legal as a reload if phase changed in this or the previous S2 cycle.
  - Otherwise err_step fires.
  - prev_valid is set by the first sample after reset that has valid segments.
- Stall check, per direction:
  - The hold counter clears on any value change or phase change; otherwise it increments and saturates.
  - err_stall pulses once when the counter reaches HOLD_MAX. It does not re-pulse until the counter has been cleared.
- Simultaneous events:
  - Every applicable pulse asserts in the same cycle.
  - first_err records the highest priority: conflict=1, seg=2, step=3, mismatch=4, stall=5.
  - first_err is latched only while it is 0.
- clr together with an error in the same cycle: the clear wins for the existing state, then the new error latches in that same cycle.
- Wrap: a displayed value going from 0 to 99 is not a step; it is legal only as a reload.

Decomposition:
- Package traffic_pkg holds:
  - the ten segment constants and SEG_BLANK;
  - the phase encoding (UNKNOWN=0, NS_GO=1, WE_GO=2, ALL_RED=3, FAULT=4);
  - the first_err codes.
- Sub-module seg7_to_bcd is combinational: 7-bit segments in, 4-bit digit and valid out. It is instantiated 8 times.

Test Plan:
- Reset, then NSGO lamps with SN=WE=25 counting down by 1 every 10 cycles for 5 steps -> no errors, phase=1, ns_count goes 25 to 20.
- GSN1=1 and GWE1=1 together -> err_conflict pulses 2 cycles later, phase=4, fault=1, first_err=1. Apply clr with a legal class -> phase recovers and fault=0.
- SN1D2 driven to 1010101 -> err_seg pulses, first_err=2, ns_count holds its previous value.
- NSGO with SN going 20 to 18 and no phase change -> err_step. NSGO to ALLRED with SN going 1 to 30 -> no error (reload).
- SN1 shows 15 while SN2 shows 16 -> err_mismatch. A value held for HOLD_MAX=20 cycles (bench override) -> exactly one err_stall pulse.
- Assert RESET low mid-sequence while fault=1 -> all outputs 0 immediately. The next valid sample raises no step error.
